// File: rtl/uart_cmd_resp.sv
// UART command/response responder: receives 8N1 command bytes and answers with a fixed
// message ("CCNU", "PLAC" or a single NAK) while the receiver keeps running.
module uart_cmd_resp #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic       rs232_tx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_drop,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CMAX = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] MSG_CCNU = 2'd0;
    localparam logic [1:0] MSG_PLAC = 2'd1;
    localparam logic [1:0] MSG_NAK  = 2'd2;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_GAP} tx_state_e;

    // ---------------- receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (rx_s2_q) begin
                        rx_byte_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= rs232_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [1:0]    tx_idx_q, tx_idx_d;
    logic [1:0]    tx_msg_q, tx_msg_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [7:0]    tx_char;
    logic [1:0]    last_idx;
    logic          accept;

    assign accept = rx_valid_q & ~busy_q;

    always_comb begin
        tx_char  = 8'h3F;
        last_idx = 2'd0;
        case (tx_msg_q)
            MSG_CCNU: begin
                last_idx = 2'd3;
                case (tx_idx_q)
                    2'd0, 2'd1: tx_char = 8'h43;
                    2'd2:       tx_char = 8'h4E;
                    default:    tx_char = 8'h55;
                endcase
            end
            MSG_PLAC: begin
                last_idx = 2'd3;
                case (tx_idx_q)
                    2'd0:    tx_char = 8'h50;
                    2'd1:    tx_char = 8'h4C;
                    2'd2:    tx_char = 8'h41;
                    default: tx_char = 8'h43;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_msg_d   = tx_msg_q;
        busy_d     = busy_q;
        if (accept) begin
            busy_d   = 1'b1;
            tx_idx_d = 2'd0;
            tx_msg_d = (rx_byte_q == 8'h31) ? MSG_CCNU :
                       (rx_byte_q == 8'h32) ? MSG_PLAC : MSG_NAK;
        end
        unique case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                if (busy_q) tx_state_d = T_START;
            end
            T_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = T_DATA;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
                end
            end
            T_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == last_idx) begin
                        tx_state_d = T_IDLE;
                        busy_d     = 1'b0;
                    end else begin
                        tx_idx_d   = tx_idx_q + 2'd1;
                        tx_state_d = (GAP_CYCLES == 0) ? T_START : T_GAP;
                    end
                end
            end
            T_GAP: begin
                if (tx_cnt_q == GAP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = T_START;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
        // Line level follows the next state so the registered output lines up with it.
        unique case (tx_state_d)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = tx_char[tx_bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_msg_q   <= MSG_NAK;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_msg_q   <= tx_msg_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
        end
    end

    assign rs232_tx  = tx_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_drop  = rx_valid_q & busy_q;
    assign busy      = busy_q;

endmodule

// File: doc/uart_cmd_resp.md
UART_CMD_RESP -- requirements
Module: uart_cmd_resp

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line rate in bit/s; DIV = CLK_HZ/BAUD (integer truncation), and DIV SHALL be at least 4.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1000, meaning the idle clk cycles inserted between response characters (0 allowed).
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rs232_rx, input, 1 bit: serial in, idle high, asynchronous to clk.
REQ-007 The block SHALL have port rs232_tx, output, 1 bit: serial out, idle high.
REQ-008 The block SHALL have port rx_byte, output, 8 bits: last correctly framed received byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_byte updates.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 The block SHALL have port cmd_drop, output, 1 bit: one-cycle pulse when a valid byte arrives while busy.
REQ-012 The block SHALL have port busy, output, 1 bit: high from command acceptance until the last response stop bit ends.

Function
REQ-013 rs232_rx SHALL pass through a 2-flop synchronizer; all RX decisions SHALL use the synchronized value.
REQ-014 RX format SHALL be 8N1, LSB first.
REQ-015 RX states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
REQ-016 R_IDLE -> R_START SHALL occur on a synchronized high-to-low edge.
REQ-017 In R_START the line SHALL be sampled at DIV/2 cycles: low -> R_DATA; high -> R_IDLE (glitch, no pulses).
REQ-018 Data bits SHALL be sampled every DIV cycles after the start-bit sample.
REQ-019 The stop bit SHALL be sampled DIV cycles after data bit 7.
- Stop high: rx_byte updates and rx_valid pulses in the same cycle.
- Stop low: frame_err pulses; rx_byte is unchanged; rx_valid stays low.
- Either way, the FSM returns to R_IDLE.
REQ-020 Command decode SHALL apply on rx_valid while busy=0:
- 0x31 -> message "CCNU" (0x43,0x43,0x4E,0x55).
- 0x32 -> message "PLAC" (0x50,0x4C,0x41,0x43).
- Any other byte -> single NAK 0x3F.
REQ-021 rx_valid while busy=1 SHALL pulse cmd_drop in the same cycle and SHALL NOT alter the message in progress.
REQ-022 TX states SHALL be T_IDLE, T_START, T_DATA, T_STOP, T_GAP.
- Each bit SHALL be exactly DIV cycles.
- T_START drives 0; T_DATA drives LSB first; T_STOP drives 1.
REQ-023 busy SHALL rise on the cycle after the accepting rx_valid.
REQ-024 rs232_tx SHALL fall (first start bit) on the cycle after busy rises.
REQ-025 After each stop bit that is not the last: T_GAP for GAP_CYCLES cycles, then T_START of the next character. If GAP_CYCLES=0, T_GAP is skipped.
REQ-026 After the last character's stop bit: T_IDLE directly, with no gap; busy SHALL fall on the first T_IDLE cycle.
REQ-027 A 2-bit character index SHALL select the message character; it SHALL reset to 0 at every command acceptance.
REQ-028 RX SHALL operate independently of and concurrently with TX.
REQ-029 rs232_tx SHALL be registered (glitch-free).

Reset
REQ-030 While rst_n=0: rs232_tx=1; busy, rx_valid, frame_err and cmd_drop=0; rx_byte=0x00; both FSMs idle; all counters 0.
REQ-031 A reset asserted mid-character SHALL abort immediately: rs232_tx returns high and no partial-byte pulses occur after release.
REQ-032 After rst_n release, the first valid start edge SHALL be accepted normally.

Verification (CLK_HZ=1000000, BAUD=100000 -> DIV=10, GAP_CYCLES=5)
REQ-033 Send 0x31 -> rx_valid pulse with rx_byte=0x31, then TX 0x43,0x43,0x4E,0x55, each 100 cycles long, with 5 idle cycles between characters, busy high throughout.
REQ-034 Send 0x32, then 0x31 during the second response character -> cmd_drop pulse; TX completes exactly 0x50,0x4C,0x41,0x43; no CCNU follows.
REQ-035 Send 0x7A -> single character 0x3F on TX; busy high for exactly 100 cycles plus 1.
REQ-036 Send 0x31 with stop bit held low -> frame_err pulse; no rx_valid; rx_byte unchanged; TX stays idle.
REQ-037 Drive a 3-cycle low glitch on rs232_rx -> no rx_valid, no frame_err; RX back in R_IDLE.
REQ-038 Assert rst_n low during the third TX character of a CCNU response -> rs232_tx high and busy 0 immediately; after release, a fresh 0x32 produces a complete PLAC.
